// File: rtl/lift_lcd_writer.sv
// lift_lcd_writer: drives a 16x2 HD44780 LCD from the lift status.
// Power-up wait, init commands, then rewrites line 1 on status change
// or on an iUPD pulse. Optional macro LIFT_LCD_LINE2_EN adds iREQ and
// a second line "DESTINO ANDAR N " written on every refresh.
module lift_lcd_writer #(
  parameter int PWRUP_WAIT = 750000,
  parameter int EN_PULSE   = 16,
  parameter int CMD_WAIT   = 2500,
  parameter int CLR_WAIT   = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [1:0] iMOV,
  input  logic [3:0] iFLOOR,
`ifdef LIFT_LCD_LINE2_EN
  input  logic [3:0] iREQ,
`endif
  input  logic       iUPD,
  output logic       oBUSY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  // Counter must reach the largest wait without wrapping.
  localparam int MAX_A = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int MAX_B = (CMD_WAIT > EN_PULSE) ? CMD_WAIT : EN_PULSE;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PW_LAST  = CW'(PWRUP_WAIT);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_PULSE - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [79:0]  S_STOP  = "PARADO    ";
  localparam logic [79:0]  S_UP    = "SUBINDO   ";
  localparam logic [79:0]  S_DOWN  = "DESCENDO  ";
  localparam logic [79:0]  S_ERR   = "ERRO      ";
  localparam logic [39:0]  S_ANDAR = "ANDAR";
  localparam logic [111:0] S_DEST  = "DESTINO ANDAR ";

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_LOAD, ST_ADDR, ST_CHARS, ST_L2ADDR, ST_L2CHARS, ST_IDLE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    data_q, byte_d;
  logic          rs_q, rs_d, en_q, busy_q;
  logic [1:0]    mov_q;
  logic [3:0]    flr_q;
  logic          chg;
  logic          send_d;
  logic [CW-1:0] hold_last;
`ifdef LIFT_LCD_LINE2_EN
  logic [3:0]    req_q;
`endif

  // Floor digit: '0'..'8', anything above shows '-'.
  function automatic logic [7:0] digit(input logic [3:0] f);
    return (f <= 4'd8) ? (8'h30 + {4'h0, f}) : 8'h2D;
  endfunction

  function automatic logic [7:0] line1_char(input logic [1:0] mov, input logic [3:0] flr,
                                            input logic [3:0] i);
    logic [79:0] s;
    logic [39:0] a;
    logic [3:0]  k;
    case (mov)
      2'd0:    s = S_STOP;
      2'd1:    s = S_UP;
      2'd2:    s = S_DOWN;
      default: s = S_ERR;
    endcase
    k = i - 4'd10;
    a = S_ANDAR << {k, 3'b000};
    s = s << {i, 3'b000};
    if (i < 4'd10)       return s[79:72];
    else if (i == 4'd15) return digit(flr);
    else                 return a[39:32];
  endfunction

  function automatic logic [7:0] line2_char(input logic [3:0] req, input logic [3:0] i);
    logic [111:0] d;
    d = S_DEST << {i, 3'b000};
    if (i < 4'd14)       return d[111:104];
    else if (i == 4'd14) return digit(req);
    else                 return 8'h20;
  endfunction

  // Pick the byte that follows the one currently on the bus.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = 8'h00;
    rs_d    = 1'b0;
    case (state_q)
      ST_INIT:  if (idx_q == 4'd3) state_d = ST_LOAD; else idx_d = idx_q + 4'd1;
      ST_ADDR:  begin state_d = ST_CHARS; idx_d = 4'd0; end
      ST_CHARS: begin
        if (idx_q == 4'd15) begin
`ifdef LIFT_LCD_LINE2_EN
          state_d = ST_L2ADDR;
`else
          state_d = ST_IDLE;
`endif
          idx_d = 4'd0;
        end else idx_d = idx_q + 4'd1;
      end
`ifdef LIFT_LCD_LINE2_EN
      ST_L2ADDR:  begin state_d = ST_L2CHARS; idx_d = 4'd0; end
      ST_L2CHARS: begin
        if (idx_q == 4'd15) begin state_d = ST_IDLE; idx_d = 4'd0; end
        else idx_d = idx_q + 4'd1;
      end
`endif
      default: ;
    endcase
    case (state_d)
      ST_INIT: begin
        case (idx_d)
          4'd0:    byte_d = 8'h38;
          4'd1:    byte_d = 8'h0C;
          4'd2:    byte_d = 8'h06;
          default: byte_d = 8'h01;
        endcase
      end
      ST_ADDR:  byte_d = 8'h80;
      ST_CHARS: begin rs_d = 1'b1; byte_d = line1_char(mov_q, flr_q, idx_d); end
`ifdef LIFT_LCD_LINE2_EN
      ST_L2ADDR:  byte_d = 8'hC0;
      ST_L2CHARS: begin rs_d = 1'b1; byte_d = line2_char(req_q, idx_d); end
`endif
      default: ;
    endcase
  end

  assign send_d    = (state_d != ST_LOAD) && (state_d != ST_IDLE);
  // The clear command needs the long settle time.
  assign hold_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;
`ifdef LIFT_LCD_LINE2_EN
  assign chg = (iMOV != mov_q) || (iFLOOR != flr_q) || (iREQ != req_q);
`else
  assign chg = (iMOV != mov_q) || (iFLOOR != flr_q);
`endif

  // Main FSM with embedded byte strobe engine (setup / pulse / hold).
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= ST_PWRUP;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
      mov_q   <= 2'd0;
      flr_q   <= 4'd0;
`ifdef LIFT_LCD_LINE2_EN
      req_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        ST_PWRUP: begin
          if (cnt_q == PW_LAST) begin
            state_q <= ST_INIT;
            idx_q   <= 4'd0;
            data_q  <= 8'h38;
            rs_q    <= 1'b0;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + CNT_ONE;
        end
        ST_LOAD: begin
          mov_q   <= iMOV;
          flr_q   <= iFLOOR;
`ifdef LIFT_LCD_LINE2_EN
          req_q   <= iREQ;
`endif
          state_q <= ST_ADDR;
          idx_q   <= 4'd0;
          data_q  <= 8'h80;
          rs_q    <= 1'b0;
          phase_q <= PH_SETUP;
          cnt_q   <= '0;
        end
        ST_IDLE: begin
          if (iUPD || chg) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          case (phase_q)
            PH_SETUP: begin
              en_q    <= 1'b1;
              phase_q <= PH_PULSE;
              cnt_q   <= '0;
            end
            PH_PULSE: begin
              if (cnt_q == EN_LAST) begin
                en_q    <= 1'b0;
                phase_q <= PH_HOLD;
                cnt_q   <= '0;
              end else cnt_q <= cnt_q + CNT_ONE;
            end
            default: begin
              if (cnt_q == hold_last) begin
                cnt_q   <= '0;
                phase_q <= PH_SETUP;
                state_q <= state_d;
                idx_q   <= idx_d;
                if (send_d) begin
                  data_q <= byte_d;
                  rs_q   <= rs_d;
                end
                if (state_d == ST_IDLE) busy_q <= 1'b0;
              end else cnt_q <= cnt_q + CNT_ONE;
            end
          endcase
        end
      endcase
    end
  end

  assign oBUSY    = busy_q;
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lift_lcd_writer.sv
// Scoreboard bench for lift_lcd_writer with small timing parameters.
module tb_lift_lcd_writer;
  localparam int PW  = 20;
  localparam int EP  = 2;
  localparam int CMW = 5;
  localparam int CLW = 10;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [1:0] iMOV;
  logic [3:0] iFLOOR;
  logic [3:0] iREQ;
  logic       iUPD;
  logic       oBUSY, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] LCD_DATA;

  always #5 iCLK = ~iCLK;

  lift_lcd_writer #(.PWRUP_WAIT(PW), .EN_PULSE(EP), .CMD_WAIT(CMW), .CLR_WAIT(CLW)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iMOV(iMOV), .iFLOOR(iFLOOR),
`ifdef LIFT_LCD_LINE2_EN
    .iREQ(iREQ),
`endif
    .iUPD(iUPD), .oBUSY(oBUSY), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS));

  typedef struct { logic rs; logic [7:0] d; int gap; } exp_t;
  exp_t sb[$];
  exp_t me;
  int   checks = 0, errors = 0;
  bit   mon_en = 0;
  int   cur_mov = 0, cur_flr = 0, cur_req = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: text of each line from the display rules ----
  function automatic logic [7:0] digit_of(input int f);
    if (f <= 8) return 8'(48 + f);
    return 8'h2D;
  endfunction

  function automatic logic [7:0] l1(input int mov, input int flr, input int i);
    string head, andar;
    andar = "ANDAR";
    case (mov)
      0:       head = "PARADO    ";
      1:       head = "SUBINDO   ";
      2:       head = "DESCENDO  ";
      default: head = "ERRO      ";
    endcase
    if (i < 10) return head[i];
    if (i < 15) return andar[i-10];
    return digit_of(flr);
  endfunction

  function automatic logic [7:0] l2(input int req, input int i);
    string s;
    s = "DESTINO ANDAR ";
    if (i < 14) return s[i];
    if (i == 14) return digit_of(req);
    return 8'h20;
  endfunction

  task automatic push(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs = rs; e.d = d; e.gap = gap;
    sb.push_back(e);
  endtask

  // gap = EN-low cycles expected before this byte, -1 = not checked
  task automatic push_refresh(input int first_gap);
    push(1'b0, 8'h80, first_gap);
    for (int i = 0; i < 16; i++) push(1'b1, l1(cur_mov, cur_flr, i), CMW + 1);
`ifdef LIFT_LCD_LINE2_EN
    push(1'b0, 8'hC0, CMW + 1);
    for (int i = 0; i < 16; i++) push(1'b1, l2(cur_req, i), CMW + 1);
`endif
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, -1);
    push(1'b0, 8'h0C, CMW + 1);
    push(1'b0, 8'h06, CMW + 1);
    push(1'b0, 8'h01, CMW + 1);
    push_refresh(CLW + 2);  // clear wait, one snapshot cycle, one setup cycle
  endtask

  // ---- monitor: pops the scoreboard on every EN rise ----
  int   high_c = 0, low_c = 0;
  logic en_prev = 1'b0;
  always @(negedge iCLK) begin
    if (!mon_en) begin
      en_prev = 1'b0; low_c = 0; high_c = 0;
    end else begin
      if (LCD_EN && !en_prev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte got=%0h rs=%0b t=%0t", LCD_DATA, LCD_RS, $time);
        end else begin
          me = sb.pop_front();
          chk("byte", {23'd0, LCD_RS, LCD_DATA}, {23'd0, me.rs, me.d});
          chk("rw_low", int'(LCD_RW), 0);
          if (me.gap >= 0) chk("en_gap", low_c, me.gap);
        end
        high_c = 1;
      end else if (LCD_EN) high_c++;
      else if (en_prev) begin
        chk("en_width", high_c, EP);
        low_c = 1;
      end else low_c++;
      en_prev = LCD_EN;
    end
  end

  task automatic tick();
    @(posedge iCLK); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((oBUSY || sb.size() != 0) && n < 3000) begin tick(); n++; end
    chk("refresh_done", int'(oBUSY || sb.size() != 0), 0);
  endtask

  task automatic quiet(input int n);
    int bad = 0;
    repeat (n) begin tick(); if (oBUSY) bad++; end
    chk("stays_idle", bad, 0);
  endtask

  task automatic do_reset();
    int k;
    iRST_N = 1'b0; mon_en = 0; iUPD = 1'b0;
    repeat (3) tick();
    chk("reset_vals", {27'd0, LCD_EN, LCD_RS, LCD_RW, oBUSY}, 1);
    chk("reset_data", int'(LCD_DATA), 0);
    sb.delete();
    push_init();
    iRST_N = 1'b1; mon_en = 1;
    for (k = 1; k <= 200; k++) begin tick(); if (LCD_EN) break; end
    chk("first_en_cycle", k, PW + 2);
    chk("first_en_data", int'(LCD_DATA), 'h38);
    wait_idle();
  endtask

  task automatic trigger(input int m, input int f, input int r, input bit upd);
    bit exp;
    exp = (m != cur_mov) || (f != cur_flr) || (r != cur_req) || upd;
    iMOV = 2'(m); iFLOOR = 4'(f); iREQ = 4'(r); iUPD = upd;
    cur_mov = m; cur_flr = f; cur_req = r;
    if (exp) push_refresh(-1);
    tick();
    iUPD = 1'b0;
    if (exp) begin
      chk("busy_rise", int'(oBUSY), 1);
      wait_idle();
    end else quiet(10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    iRST_N = 1'b0; iMOV = 2'd0; iFLOOR = 4'd0; iUPD = 1'b0;
`ifdef LIFT_LCD_LINE2_EN
    cur_req = 5;
`endif
    iREQ = 4'(cur_req);
    do_reset();

    trigger(1, 3, cur_req, 1'b0);

    // floor changes mid-line: current line ends with old floor, then a new refresh
    iUPD = 1'b1; push_refresh(-1); tick(); iUPD = 1'b0;
    n = 0;
    while (sb.size() > 8 && n < 1000) begin tick(); n++; end
    iFLOOR = 4'd4; cur_flr = 4;
    push_refresh(-1);
    wait_idle();
    quiet(20);

    // iUPD while busy is dropped
    iUPD = 1'b1; push_refresh(-1); tick(); iUPD = 1'b0;
    repeat (4) tick();
    iUPD = 1'b1; tick(); iUPD = 1'b0;
    wait_idle();
    quiet(30);

    trigger(2, 12, cur_req, 1'b0);
    trigger(3, 12, cur_req, 1'b0);
    trigger(3, 12, cur_req, 1'b1);
    trigger(3, 12, cur_req, 1'b0);

    // reset while EN is high mid-refresh
    iMOV = 2'd0; cur_mov = 0; push_refresh(-1);
    n = 0;
    while (!(LCD_EN && sb.size() < 12) && n < 2000) begin tick(); n++; end
    iRST_N = 1'b0; mon_en = 0;
    tick();
    chk("midreset_ctl", {28'd0, LCD_EN, LCD_RS, oBUSY}, 1);
    chk("midreset_data", int'(LCD_DATA), 0);
    do_reset();

    for (int it = 0; it < 10; it++) begin
      int m, f, r;
      bit u;
      m = int'($urandom_range(3, 0));
      f = int'($urandom_range(15, 0));
      u = 1'($urandom_range(1, 0));
`ifdef LIFT_LCD_LINE2_EN
      r = int'($urandom_range(15, 0));
`else
      r = 0;
`endif
      if ($urandom_range(3, 0) == 0) begin m = cur_mov; f = cur_flr; r = cur_req; end
      trigger(m, f, r, u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lift_lcd_writer.md
Name: lift_lcd_writer

Overview:
- Display end of the lift status interface. Consumes the controller's movement code and current floor, and drives a 16x2 HD44780-compatible character LCD over its 8-bit parallel bus.
- Performs the power-up/init sequence, then rewrites line 1 whenever the status changes or a refresh is requested.
- Sits between the lift controller and the board LCD pins. Replaces the ad-hoc LCD test driver.

Parameters:
- PWRUP_WAIT, 750000, cycles idle after reset before first command (15 ms at 50 MHz)
- EN_PULSE, 16, cycles LCD_EN held high per byte
- CMD_WAIT, 2500, cycles after EN falls before the next byte (50 us)
- CLR_WAIT, 100000, cycles after EN falls following the 0x01 clear command (2 ms)

Ports:
- iCLK  in  1  system clock (CLOCK_50)
- iRST_N  in  1  reset, synchronous, active-low
- iMOV  in  2  movement: 0 stopped, 1 up, 2 down, 3 invalid
- iFLOOR  in  4  current floor, 0..8 valid
- iUPD  in  1  single-cycle forced refresh request
- oBUSY  out  1  high while init or a refresh is in progress
- LCD_DATA  out  8  LCD data bus
- LCD_RW  out  1  always 0 (write only)
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  0 = command, 1 = character data

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: LCD_DATA=0, LCD_RS=0, LCD_RW=0, LCD_EN=0, oBUSY=1.
- Reset asserted mid-operation: all outputs return to reset values on the next edge, the FSM goes to PWRUP, and any partial transfer is abandoned.

Byte transfer sub-sequence (every byte):
- Cycle 0: load LCD_DATA/LCD_RS, EN=0 (setup).
- Then EN=1 for exactly EN_PULSE cycles.
- Then EN=0 with DATA/RS held for CMD_WAIT cycles (CLR_WAIT if the byte was command 0x01).
- Next byte starts on the following cycle.

FSM states and transitions:
- PWRUP: count PWRUP_WAIT cycles -> INIT.
  - First LCD_EN rise occurs PWRUP_WAIT+2 cycles after iRST_N release.
- INIT: commands 0x38, 0x0C, 0x06, 0x01, in order -> LOAD.
- LOAD: snapshot iMOV/iFLOOR into internal registers (single cycle) -> ADDR.
- ADDR: command 0x80 -> CHARS.
- CHARS: 16 data bytes from the snapshot, left to right -> IDLE.
- IDLE: oBUSY=0.
  - Go to LOAD if iUPD=1, or if iMOV/iFLOOR differ from the snapshot.
  - Inputs changing during a refresh are therefore picked up immediately after it ends.
  - iUPD pulses arriving while busy are dropped.

Line 1 content (ASCII, 16 characters):
- Chars 0-9, by iMOV:
  - 0: "PARADO    "
  - 1: "SUBINDO   "
  - 2: "DESCENDO  "
  - 3: "ERRO      "
- Chars 10-15: "ANDAR" followed by a digit.
  - Digit = 0x30+floor for floor 0..8.
  - Floor 9..15 shows '-' (0x2D).

Counter width: must hold max(PWRUP_WAIT, CLR_WAIT) with no wrap. The counter resets to 0 at every phase entry.

Optional Feature:
- Macro: LIFT_LCD_LINE2_EN.
- Defined:
  - Adds input iREQ[3:0] (requested floor).
  - Every refresh also writes command 0xC0, then 16 characters "DESTINO ANDAR N ", with N encoded by the floor-digit rule.
  - iREQ is part of the snapshot and of change detection.
- Undefined:
  - The iREQ port does not exist.
  - Only line 1 is written; a refresh is exactly 17 bytes.

Test Plan:
- Small params (PWRUP_WAIT=20, EN_PULSE=2, CMD_WAIT=5, CLR_WAIT=10). Release reset with iMOV=0, iFLOOR=0.
  - Required: EN rises first at cycle 22 with DATA=0x38, RS=0.
  - Required: init bytes 0x38, 0x0C, 0x06, 0x01; 0x01 followed by 10 idle cycles.
  - Required: then 0x80, then "PARADO    ANDAR0"; oBUSY falls after the final byte.
- In IDLE, set iMOV=1, iFLOOR=3.
  - Required: oBUSY rises the next cycle; bytes 0x80, then "SUBINDO   ANDAR3".
- During the CHARS phase, change iFLOOR 3->4.
  - Required: the current line completes with '3'.
  - Required: a second refresh starts immediately after, with '4'.
- iMOV=2, iFLOOR=12 -> "DESCENDO  ANDAR-". iMOV=3 -> "ERRO      " prefix.
- Assert iRST_N=0 while EN=1 mid-byte.
  - Required: next edge EN=0, DATA=0, oBUSY=1.
  - Required: on release, the full PWRUP/INIT sequence repeats.
- Pulse iUPD once in IDLE with unchanged inputs.
  - Required: exactly one 17-byte refresh (34 bytes with LIFT_LCD_LINE2_EN defined and iREQ=5, line 2 "DESTINO ANDAR 5 ").
  - Required: LCD_RW=0 throughout.
